// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte transmitter.
// Holds the grant until a packet's last byte drains; a lock timeout frees stalled owners.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_busy,
  output logic [1:0]             o_grant_id,
  output logic                   o_grant_active,
  output logic                   o_timeout_pulse
);

  localparam int unsigned IDW   = 2;
  localparam int unsigned SLOTS = 4;
  localparam int unsigned BYTEW = 8;
  localparam int unsigned DATAW = SLOTS * BYTEW;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned RRW   = 3;

  localparam logic [IDW-1:0]  LAST_GRANT_RST = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] TO_LIMIT       = CNTW'(LOCK_TIMEOUT);
  localparam logic [CNTW-1:0] CNT_MAX        = '1;
  localparam bit              TO_EN          = (LOCK_TIMEOUT != 0);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..4");
  end
  if (LOCK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: LOCK_TIMEOUT must fit in 16 bits");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LAUNCH = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_grant_id;
  logic [IDW-1:0]     r_last_grant;
  logic               r_grant_active;
  logic               r_tx_start;
  logic [BYTEW-1:0]   r_tx_data;
  logic               r_last_flag;
  logic [CNTW-1:0]    r_to_cnt;
  logic               r_timeout_pulse;

  state_t             w_state_nxt;
  logic [IDW-1:0]     w_grant_id_nxt;
  logic [IDW-1:0]     w_last_grant_nxt;
  logic               w_tx_start_nxt;
  logic [BYTEW-1:0]   w_tx_data_nxt;
  logic               w_last_flag_nxt;
  logic [CNTW-1:0]    w_to_cnt_nxt;
  logic               w_timeout_nxt;

  logic [SLOTS-1:0]   w_valid4;
  logic [SLOTS-1:0]   w_last4;
  logic [DATAW-1:0]   w_data4;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic               w_rr_any;
  logic [IDW-1:0]     w_rr_id;
  logic [RRW-1:0]     w_rr_idx;

  // Requester buses widened to four slots so a 2-bit id always indexes in range.
  assign w_valid4 = SLOTS'(i_req_valid);
  assign w_last4  = SLOTS'(i_req_last);
  assign w_data4  = DATAW'(i_req_data);

  // Ready depends only on state, grant holder and transmitter busy.
  always_comb begin
    w_req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_req_ready[i] = (r_state == S_GRANT) && !i_tx_busy && (r_grant_id == IDW'(i));
    end
  end

  assign w_accept = |(w_req_ready & i_req_valid);

  // Round-robin search from last_grant+1; descending scan lets the nearest slot win.
  always_comb begin
    w_rr_any = 1'b0;
    w_rr_id  = r_last_grant;
    w_rr_idx = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      w_rr_idx = RRW'(r_last_grant) + RRW'(k);
      if (w_rr_idx >= RRW'(NUM_REQ)) begin
        w_rr_idx = w_rr_idx - RRW'(NUM_REQ);
      end
      if (w_valid4[w_rr_idx[IDW-1:0]]) begin
        w_rr_any = 1'b1;
        w_rr_id  = w_rr_idx[IDW-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_last_flag_nxt  = r_last_flag;
    w_to_cnt_nxt     = r_to_cnt;
    w_timeout_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_to_cnt_nxt = '0;
        if (w_rr_any) begin
          w_grant_id_nxt = w_rr_id;
          w_state_nxt    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept) begin
          w_tx_data_nxt   = w_data4[{r_grant_id, 3'b000} +: BYTEW];
          w_last_flag_nxt = w_last4[r_grant_id];
          w_to_cnt_nxt    = '0;
          w_tx_start_nxt  = 1'b1;
          w_state_nxt     = S_LAUNCH;
        end else if (TO_EN && (r_to_cnt == TO_LIMIT)) begin
          // Stalled owner: abandon the partial packet and move the pointer past it.
          w_timeout_nxt    = 1'b1;
          w_last_grant_nxt = r_grant_id;
          w_state_nxt      = S_IDLE;
        end else if (!w_valid4[r_grant_id] && (r_to_cnt != CNT_MAX)) begin
          w_to_cnt_nxt = r_to_cnt + CNTW'(1);
        end
      end
      S_LAUNCH: begin
        if (i_tx_busy) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!i_tx_busy) begin
          if (r_last_flag) begin
            w_last_grant_nxt = r_grant_id;
            w_state_nxt      = S_IDLE;
          end else begin
            w_state_nxt = S_GRANT;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_grant_id      <= '0;
      r_last_grant    <= LAST_GRANT_RST;
      r_grant_active  <= 1'b0;
      r_tx_start      <= 1'b0;
      r_tx_data       <= '0;
      r_last_flag     <= 1'b0;
      r_to_cnt        <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_grant_id      <= w_grant_id_nxt;
      r_last_grant    <= w_last_grant_nxt;
      r_grant_active  <= (w_state_nxt != S_IDLE);
      r_tx_start      <= w_tx_start_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_last_flag     <= w_last_flag_nxt;
      r_to_cnt        <= w_to_cnt_nxt;
      r_timeout_pulse <= w_timeout_nxt;
    end
  end

  assign o_req_ready     = w_req_ready;
  assign o_tx_start      = r_tx_start;
  assign o_tx_data       = r_tx_data;
  assign o_grant_id      = r_grant_id;
  assign o_grant_active  = r_grant_active;
  assign o_timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: lock-level reference model checked every cycle,
// directed scenarios with hand-computed timing, and a randomized traffic phase.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int TO = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid, req_last, req_ready;
  logic [23:0] req_data;
  logic        tx_start, tx_busy, grant_active, timeout_pulse;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  logic        z_rst;
  logic [2:0]  z_valid, z_last, z_ready;
  logic [23:0] z_data;
  logic        z_tx_start, z_busy, z_grant_active, z_timeout_pulse;
  logic [7:0]  z_tx_data;
  logic [1:0]  z_grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(TO)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .i_tx_busy(tx_busy), .o_grant_id(grant_id),
    .o_grant_active(grant_active), .o_timeout_pulse(timeout_pulse));

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(0)) u_dut_noto (
    .i_clk(clk), .i_rst(z_rst), .i_req_valid(z_valid), .i_req_data(z_data),
    .i_req_last(z_last), .o_req_ready(z_ready), .o_tx_start(z_tx_start),
    .o_tx_data(z_tx_data), .i_tx_busy(z_busy), .o_grant_id(z_grant_id),
    .o_grant_active(z_grant_active), .o_timeout_pulse(z_timeout_pulse));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] q [NR][$];
  bit  rnd_mode = 0;
  int  stall [NR];
  int  busy_len = 5;
  int  busy_rem = 0;
  int  z_busy_rem = 0;
  int  z_tp_cnt = 0;

  int ev_start_cyc[$], ev_start_gid[$], ev_start_data[$], ev_tp_cyc[$], ev_ready_cyc[$];

  // Reference: who holds the lock, and where its current byte is in its life.
  bit         m_hold;
  int         m_gid, m_lastg, m_phase, m_cnt;
  bit         m_lastflag, m_start, m_tp;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_chk(input string nm, input int n, input int maxc);
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s wait bound expired actual=%0d required<%0d", nm, n, maxc);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_gid = 0; m_lastg = NR - 1; m_phase = 0; m_cnt = 0;
    m_lastflag = 0; m_start = 0; m_tp = 0; m_data = 8'h00;
  endtask

  task automatic model_compare();
    logic [2:0] er;
    er = 3'b000;
    if (m_hold && m_phase == 0 && !tx_busy) er[m_gid] = 1'b1;
    chk("grant_active",  32'(grant_active),  32'(m_hold));
    chk("grant_id",      32'(grant_id),      32'(m_gid));
    chk("tx_start",      32'(tx_start),      32'(m_start));
    chk("tx_data",       32'(tx_data),       32'(m_data));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
    chk("req_ready",     32'(req_ready),     32'(er));
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
      return;
    end
    m_start = 0;
    m_tp = 0;
    if (!m_hold) begin
      for (int off = 1; off <= NR; off++) begin
        int idx;
        idx = (m_lastg + off) % NR;
        if (req_valid[idx]) begin
          m_hold = 1; m_gid = idx; m_phase = 0; m_cnt = 0;
          break;
        end
      end
    end else if (m_phase == 0) begin
      if (req_valid[m_gid] && !tx_busy) begin
        m_data = req_data[8*m_gid +: 8];
        m_lastflag = req_last[m_gid];
        m_cnt = 0; m_start = 1; m_phase = 1;
      end else if (TO != 0 && m_cnt == TO) begin
        m_tp = 1; m_lastg = m_gid; m_hold = 0;
      end else if (!req_valid[m_gid] && m_cnt < 65535) begin
        m_cnt++;
      end
    end else if (m_phase == 1) begin
      if (tx_busy) m_phase = 2;
    end else begin
      if (!tx_busy) begin
        if (m_lastflag) begin
          m_hold = 0; m_lastg = m_gid;
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      logic v;
      logic [8:0] h;
      v = (q[i].size() > 0);
      if (rnd_mode) begin
        if (stall[i] > 0) begin
          stall[i]--; v = 0;
        end else if ($urandom_range(0, 99) < 2) begin
          stall[i] = $urandom_range(17, 40); v = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          v = 0;
        end
      end
      h = (q[i].size() > 0) ? q[i][0] : {1'($urandom), 8'($urandom)};
      req_valid[i] = v;
      req_data[8*i +: 8] = h[7:0];
      req_last[i] = h[8];
    end
  endtask

  task automatic clear_ev();
    ev_start_cyc.delete(); ev_start_gid.delete(); ev_start_data.delete();
    ev_tp_cyc.delete(); ev_ready_cyc.delete();
  endtask

  task automatic step();
    logic [2:0] acc;
    logic st, zst;
    @(negedge clk);
    model_compare();
    if (tx_start) begin
      ev_start_cyc.push_back(cyc); ev_start_gid.push_back(int'(grant_id));
      ev_start_data.push_back(int'(tx_data));
    end
    if (timeout_pulse) ev_tp_cyc.push_back(cyc);
    if (req_ready != 3'b000) ev_ready_cyc.push_back(cyc);
    if (z_timeout_pulse) z_tp_cnt++;
    acc = req_valid & req_ready;
    st = tx_start;
    zst = z_tx_start;
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    if (st) busy_rem = rnd_mode ? int'($urandom_range(1, 6)) : busy_len;
    else if (busy_rem > 0) busy_rem--;
    tx_busy = (busy_rem > 0);
    if (zst) z_busy_rem = 5;
    else if (z_busy_rem > 0) z_busy_rem--;
    z_busy = (z_busy_rem > 0);
    for (int i = 0; i < NR; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive_reqs();
    #1;
  endtask

  task automatic run_idle(input int maxc, input string nm);
    int n;
    n = 0;
    while (!(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
             !grant_active && busy_rem == 0) && n < maxc) begin
      step();
      n++;
    end
    bound_chk(nm, n, maxc);
    step();
  endtask

  task automatic pulse_rst();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    int n0, s0, g, n;
    int exp_d[3];
    int exp_own[8];
    int exp_gap[7];
    rst = 1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 0;
    z_rst = 1; z_valid = '0; z_data = '0; z_last = '0; z_busy = 0;
    for (int i = 0; i < NR; i++) stall[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    step();
    rst = 0;
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single requester: three bytes from requester 1.
    clear_ev(); busy_len = 5;
    q[1].push_back({1'b0, 8'hA5}); q[1].push_back({1'b0, 8'h10}); q[1].push_back({1'b1, 8'h5A});
    n0 = cyc;
    drive_reqs();
    run_idle(200, "single_wait");
    exp_d = '{'hA5, 'h10, 'h5A};
    chk("single_count", 32'(ev_start_cyc.size()), 32'd3);
    for (int k = 0; k < 3 && k < ev_start_cyc.size(); k++) begin
      chk("single_data", 32'(ev_start_data[k]), 32'(exp_d[k]));
      chk("single_gid", 32'(ev_start_gid[k]), 32'd1);
    end
    if (ev_start_cyc.size() > 0) chk("single_latency", 32'(ev_start_cyc[0] - n0), 32'd2);
    chk("single_idle", 32'(grant_active), 32'd0);

    // Round robin: all requesters loaded from reset, requester 0 with two packets.
    clear_ev();
    for (int p = 0; p < 2; p++) begin
      q[0].push_back({1'b0, 8'(8'h40 + 2*p)}); q[0].push_back({1'b1, 8'(8'h41 + 2*p)});
    end
    q[1].push_back({1'b0, 8'h50}); q[1].push_back({1'b1, 8'h51});
    q[2].push_back({1'b0, 8'h60}); q[2].push_back({1'b1, 8'h61});
    rst = 1; drive_reqs(); step(); rst = 0;
    run_idle(400, "rr_wait");
    exp_own = '{0, 0, 1, 1, 2, 2, 0, 0};
    exp_gap = '{8, 9, 8, 9, 8, 9, 8};
    chk("rr_count", 32'(ev_start_cyc.size()), 32'd8);
    for (int k = 0; k < 8 && k < ev_start_cyc.size(); k++) begin
      chk("rr_owner", 32'(ev_start_gid[k]), 32'(exp_own[k]));
      if (k > 0) chk("rr_gap", 32'(ev_start_cyc[k] - ev_start_cyc[k-1]), 32'(exp_gap[k-1]));
    end

    // Long transmitter frame.
    clear_ev(); busy_len = 4340;
    q[2].push_back({1'b0, 8'h11}); q[2].push_back({1'b1, 8'h22});
    drive_reqs();
    run_idle(10000, "busy_wait");
    chk("busy_count", 32'(ev_start_cyc.size()), 32'd2);
    if (ev_start_cyc.size() == 2) begin
      chk("busy_gap", 32'(ev_start_cyc[1] - ev_start_cyc[0]), 32'd4343);
      chk("busy_data1", 32'(ev_start_data[1]), 32'h22);
    end

    // Lock timeout: requester 0 goes silent mid-packet while requester 2 waits.
    busy_len = 5;
    pulse_rst();
    clear_ev();
    q[0].push_back({1'b0, 8'h77});
    q[2].push_back({1'b1, 8'h99});
    drive_reqs();
    run_idle(300, "to_wait");
    chk("to_pulses", 32'(ev_tp_cyc.size()), 32'd1);
    chk("to_starts", 32'(ev_start_cyc.size()), 32'd2);
    if (ev_start_cyc.size() == 2 && ev_tp_cyc.size() == 1) begin
      s0 = ev_start_cyc[0];
      g = -1;
      foreach (ev_ready_cyc[k]) if (g < 0 && ev_ready_cyc[k] > s0) g = ev_ready_cyc[k];
      chk("to_grant_cycle", 32'(g - s0), 32'd7);
      chk("to_delay", 32'(ev_tp_cyc[0] - g), 32'd17);
      chk("to_next_owner", 32'(ev_start_gid[1]), 32'd2);
      chk("to_next_start", 32'(ev_start_cyc[1] - ev_tp_cyc[0]), 32'd2);
    end

    // Reset while a byte is draining.
    clear_ev(); busy_len = 20;
    q[1].push_back({1'b0, 8'h31}); q[1].push_back({1'b1, 8'h32});
    drive_reqs();
    n = 0;
    while (ev_start_cyc.size() == 0 && n < 50) begin step(); n++; end
    bound_chk("mid_rst_start", n, 50);
    s0 = (ev_start_cyc.size() > 0) ? ev_start_cyc[0] : cyc;
    repeat (4) step();
    rst = 1; step(); rst = 0;
    chk("mid_rst_active", 32'(grant_active), 32'd0);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    chk("mid_rst_tp", 32'(timeout_pulse), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    n = 0;
    while (req_ready == 3'b000 && n < 100) begin step(); n++; end
    bound_chk("mid_rst_ready_wait", n, 100);
    chk("mid_rst_ready_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready_cycle", 32'(cyc - s0), 32'd21);
    run_idle(300, "mid_rst_drain");
    busy_len = 5;

    // Timeout disabled: silent owner keeps its lock.
    z_rst = 0; z_tp_cnt = 0;
    z_valid = 3'b001; z_data = 24'h00003C; z_last = 3'b000;
    n = 0;
    while (!(z_valid[0] && z_ready[0]) && n < 20) begin step(); n++; end
    bound_chk("noto_accept", n, 20);
    step();
    z_valid = 3'b010;
    repeat (3000) step();
    chk("noto_pulses", 32'(z_tp_cnt), 32'd0);
    chk("noto_active", 32'(z_grant_active), 32'd1);
    chk("noto_gid", 32'(z_grant_id), 32'd0);
    chk("noto_ready", 32'(z_ready), 32'b001);
    chk("noto_data", 32'(z_tx_data), 32'h3C);

    // Randomized traffic.
    pulse_rst();
    clear_ev();
    rnd_mode = 1;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      step();
    end
    rnd_mode = 0;
    for (int i = 0; i < NR; i++) stall[i] = 0;
    run_idle(3000, "rnd_drain");
    chk("rnd_activity", 32'(ev_start_cyc.size() > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
